// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: receive side of the scanned 7-segment bus.
// Watches the active-low an/sseg lines, waits for each digit dwell to settle and
// rebuilds the four hex digits, decimal points and per-digit status.
// Optional build macro SSEG_CAP_ERRCNT_EN adds an 8-bit saturating err_count
// output (undecodable captures plus dwells abandoned during settling).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a single active digit enable
// SETTLE  | snapshot held, counting consecutive stable cycles
// CAPTURE | one cycle: decode the snapshot into its digit slot
// HOLD    | digit already taken for this dwell, wait for the bus to move
module sseg_scan_capture #(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_out,
  output logic [3:0] digit_valid,
  output logic [3:0] blank,
  output logic       frame_done,
  output logic       seg_err,
  output logic       stalled
`ifdef SSEG_CAP_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  logic [11:0]   sync_q [SYNC_STAGES];
  logic [11:0]   cur;
  logic [11:0]   snap;
  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] idle_cnt;
  logic [3:0]    mask;
  logic [3:0]    mask_next;
  logic [1:0]    cap_idx;
  logic [3:0]    dec_val;
  logic          dec_hit;
  logic          cur_ok;

  assign cur       = sync_q[SYNC_STAGES-1];
  assign cur_ok    = $onehot(~cur[11:8]);
  assign mask_next = mask | ~snap[11:8];

  // Bring the asynchronous display bus into the clock domain; idle level is all-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 12'hFFF;
    end else begin
      sync_q[0] <= {an, sseg};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Digit slot addressed by the single low enable in the snapshot.
  always_comb begin
    cap_idx = 2'd0;
    case (snap[11:8])
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: cap_idx = 2'd0;
    endcase
  end

  // Active-low a..g pattern to hex value.
  always_comb begin
    dec_hit = 1'b1;
    dec_val = 4'h0;
    case (snap[6:0])
      7'h01: dec_val = 4'h0;
      7'h4F: dec_val = 4'h1;
      7'h12: dec_val = 4'h2;
      7'h06: dec_val = 4'h3;
      7'h4C: dec_val = 4'h4;
      7'h24: dec_val = 4'h5;
      7'h20: dec_val = 4'h6;
      7'h0F: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h04: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h60: dec_val = 4'hB;
      7'h31: dec_val = 4'hC;
      7'h42: dec_val = 4'hD;
      7'h30: dec_val = 4'hE;
      7'h38: dec_val = 4'hF;
      default: dec_hit = 1'b0;
    endcase
  end

  // Dwell tracking, capture into the digit registers, frame and stall bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      snap        <= 12'h000;
      settle_cnt  <= '0;
      idle_cnt    <= '0;
      mask        <= 4'h0;
      hex3        <= 4'h0;
      hex2        <= 4'h0;
      hex1        <= 4'h0;
      hex0        <= 4'h0;
      dp_out      <= 4'h0;
      digit_valid <= 4'h0;
      blank       <= 4'h0;
      frame_done  <= 1'b0;
      seg_err     <= 1'b0;
      stalled     <= 1'b0;
`ifdef SSEG_CAP_ERRCNT_EN
      err_count   <= 8'h00;
`endif
    end else begin
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (cur_ok) begin
            state      <= SETTLE;
            snap       <= cur;
            settle_cnt <= SW'(SETTLE_CYCLES);
          end
        end
        SETTLE: begin
          if (cur == snap) begin
            if (settle_cnt == SW'(1)) state <= CAPTURE;
            else settle_cnt <= settle_cnt - SW'(1);
          end else if (cur_ok) begin
            snap       <= cur;
            settle_cnt <= SW'(SETTLE_CYCLES);
          end else begin
            state <= IDLE;
`ifdef SSEG_CAP_ERRCNT_EN
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
          end
        end
        CAPTURE: begin
          state           <= HOLD;
          dp_out[cap_idx] <= ~snap[7];
          if (dec_hit) begin
            case (cap_idx)
              2'd0:    hex0 <= dec_val;
              2'd1:    hex1 <= dec_val;
              2'd2:    hex2 <= dec_val;
              default: hex3 <= dec_val;
            endcase
            blank[cap_idx]       <= 1'b0;
            digit_valid[cap_idx] <= 1'b1;
          end else if (snap[6:0] == 7'h7F) begin
            blank[cap_idx]       <= 1'b1;
            digit_valid[cap_idx] <= 1'b1;
          end else begin
            seg_err              <= 1'b1;
            digit_valid[cap_idx] <= 1'b0;
`ifdef SSEG_CAP_ERRCNT_EN
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
          end
          // A completed frame clears the mask in the same edge that completes it.
          frame_done <= (mask_next == 4'hF);
          mask       <= (mask_next == 4'hF) ? 4'h0 : mask_next;
        end
        default: begin
          if (cur != snap) state <= IDLE;
        end
      endcase

      // Capture always takes priority over an expiring stall timer.
      if (state == CAPTURE) begin
        idle_cnt <= '0;
        stalled  <= 1'b0;
      end else if (!stalled) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          stalled     <= 1'b1;
          digit_valid <= 4'h0;
          mask        <= 4'h0;
          idle_cnt    <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end

endmodule
